bsg_manycore_endpoint_out_sched: RTL and testbench
==================================================

// Module: bsg_manycore_endpoint_out_sched
// PURPOSE
//  Shares one manycore endpoint's outgoing forward-packet port among num_req_p local requesters.
//  Round-robin arbitration; issue gated by a return-credit counter that limits packets in flight.
//  Counter is replenished by the endpoint's registered credit pulse. Supports a fence (drain) request
//  that halts issue until every outstanding packet has returned its credit.
//  Sits between tile-local request sources and the endpoint's out_packet/out_v/out_ready port.
// PARAMETERS
//  num_req_p          4      number of requesters (>=1)
//  packet_width_p     "inv"  forward packet width; must equal the endpoint packet width
//  max_out_credits_p  16     max packets in flight (>=1)
//  credit_width_lp    $clog2(max_out_credits_p+1)  derived; width of the credit counter
// PORTS
//  clk_i              in   1                          clock
//  reset_n_i          in   1                          synchronous reset, active low
//  req_v_i            in   num_req_p                  per-requester packet valid
//  req_data_i         in   num_req_p*packet_width_p   per-requester packet; slot i = bits [i*pw +: pw]
//  req_yumi_o         out  num_req_p                  one-hot; requester i's packet consumed this cycle
//  out_packet_o       out  packet_width_p             packet to endpoint
//  out_v_o            out  1                          packet valid to endpoint
//  out_ready_i        in   1                          endpoint ready
//  credit_v_i         in   1                          one-cycle credit-return pulse from endpoint
//  fence_v_i          in   1                          fence request
//  fence_ready_o      out  1                          fence accepted when fence_v_i & fence_ready_o
//  fence_done_o       out  1                          one-cycle pulse: fence complete
//  out_credits_o      out  credit_width_lp            current credit count (registered)
//  credit_overflow_o  out  1                          sticky error: credit returned with none outstanding
// BEHAVIOUR
//  Reset (reset_n_i=0 at posedge):
//   - credit_cnt_r <= max_out_credits_p; state <= RUN; rr last pointer <= num_req_p-1 (req 0 wins first).
//   - credit_overflow_o <= 0.
//   - While reset_n_i=0: out_v_o, req_yumi_o, fence_ready_o and fence_done_o are forced to 0.
//  Issue (combinational on registered state):
//   - can_issue = (state==RUN) & (credit_cnt_r!=0).
//   - grant = first req_v_i bit at or after (last+1) mod num_req_p, searching upward with wrap.
//   - out_v_o = can_issue & |req_v_i; out_packet_o = grant's slot; fire = out_v_o & out_ready_i.
//   - req_yumi_o = grant one-hot & fire; zero latency, at most one bit set.
//   - last <= grant index on fire only; pointer holds when nothing fires.
//   - Requesters must hold req_v_i/data until yumi, so grant is stable while out_v_o waits on out_ready_i.
//  Credit counter:
//   - next = credit_cnt_r - fire + credit_v_i; fire and credit in same cycle -> unchanged.
//   - credit_v_i with credit_cnt_r==max_out_credits_p: set credit_overflow_o (sticky to reset);
//     count saturates at max (next = max - fire).
//   - A credit arriving while credit_cnt_r==0 does not enable issue that same cycle; issue resumes next cycle.
//  Fence FSM (states RUN, DRAIN):
//   - RUN: fence_ready_o=1. On fence_v_i -> DRAIN; a packet firing in the acceptance cycle belongs to the fence.
//   - DRAIN: fence_ready_o=0 and no issue. When credit_cnt_r==max: fence_done_o=1 for that cycle -> RUN.
//   - Fence accepted with nothing outstanding completes on the first DRAIN cycle (1 cycle after acceptance).
//   - Reset mid-DRAIN returns to RUN with no fence_done_o pulse.
// TESTING
//  1. Reset, then req_v_i=4'b1111 held, out_ready_i=1, no credits -> yumi order 0,1,2,3,0,...
//     16 fires, out_v_o=0 from cycle 17, out_credits_o=0.
//  2. Credit count at 0; one credit_v_i pulse -> out_credits_o=1 next cycle, exactly one fire, count back to 0.
//  3. req_v_i=4'b0101, out_ready_i toggling 1/0 -> grants alternate 0,2,0,2; data held stable while
//     out_ready_i=0; yumi only on ready cycles.
//  4. Count=5; fire and credit_v_i in same cycle -> out_credits_o stays 5; last pointer advances.
//  5. 3 packets outstanding, fence_v_i pulse -> fence_ready_o=0, no issue; after 3 credits,
//     fence_done_o pulses 1 cycle with out_credits_o=16, then issue resumes.
//  6. Count=16, credit_v_i pulse -> credit_overflow_o=1 and stays 1; count stays 16.
//     Reset during DRAIN -> RUN, fence_ready_o=1, no done pulse.

Source files
------------

// File: rtl/bsg_manycore_endpoint_out_sched.sv
// Round-robin scheduler sharing one endpoint forward-packet port among num_req_p requesters, credit-limited, with fence/drain.
// Latency: zero-cycle grant (req_v_i -> out_v_o/req_yumi_o combinational); credit count and fence state are registered.
// Backpressure: out_ready_i low holds the grant; zero credits or an active drain block issue; requesters hold data until yumi.
module bsg_manycore_endpoint_out_sched #(
    parameter int num_req_p         = 4,
    parameter int packet_width_p    = 32,
    parameter int max_out_credits_p = 16,
    localparam int credit_width_lp  = $clog2(max_out_credits_p + 1),
    localparam int lg_req_lp        = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic [num_req_p-1:0]                req_v_i,
    input  logic [num_req_p*packet_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]                req_yumi_o,
    output logic [packet_width_p-1:0]           out_packet_o,
    output logic                                out_v_o,
    input  logic                                out_ready_i,
    input  logic                                credit_v_i,
    input  logic                                fence_v_i,
    output logic                                fence_ready_o,
    output logic                                fence_done_o,
    output logic [credit_width_lp-1:0]          out_credits_o,
    output logic                                credit_overflow_o
);

    typedef enum logic {RUN, DRAIN} state_e;

    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

    state_e                     state_r;
    logic [credit_width_lp-1:0] credit_cnt_r;
    logic [credit_width_lp-1:0] credit_n;
    logic [lg_req_lp-1:0]       last_r;
    logic [lg_req_lp-1:0]       grant_idx;
    logic                       grant_found;
    logic                       can_issue;
    logic                       fire;
    logic                       all_returned;

    // Search upward from the requester after the last winner, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < num_req_p; k++) begin
            if (!grant_found && req_v_i[(int'(last_r) + 1 + k) % num_req_p]) begin
                grant_found = 1'b1;
                grant_idx   = lg_req_lp'((int'(last_r) + 1 + k) % num_req_p);
            end
        end
    end

    assign all_returned = (credit_cnt_r == max_credits_lp);
    assign can_issue    = reset_n_i && (state_r == RUN) && (credit_cnt_r != '0);
    assign out_v_o      = can_issue && grant_found;
    assign fire         = out_v_o && out_ready_i;
    assign out_packet_o = req_data_i[grant_idx*packet_width_p +: packet_width_p];

    always_comb begin
        req_yumi_o = '0;
        if (fire) begin
            req_yumi_o[grant_idx] = 1'b1;
        end
    end

    assign fence_ready_o     = reset_n_i && (state_r == RUN);
    assign fence_done_o      = reset_n_i && (state_r == DRAIN) && all_returned;
    assign out_credits_o     = credit_cnt_r;

    // A credit returned with nothing outstanding is dropped so the count saturates at max.
    always_comb begin
        credit_n = credit_cnt_r;
        if (fire) begin
            credit_n = credit_n - credit_width_lp'(1);
        end
        if (credit_v_i && !all_returned) begin
            credit_n = credit_n + credit_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r           <= RUN;
            credit_cnt_r      <= max_credits_lp;
            last_r            <= lg_req_lp'(num_req_p - 1);
            credit_overflow_o <= 1'b0;
        end else begin
            credit_cnt_r <= credit_n;
            if (fire) begin
                last_r <= grant_idx;
            end
            if (credit_v_i && all_returned) begin
                credit_overflow_o <= 1'b1;
            end
            case (state_r)
                RUN:     if (fence_v_i) state_r <= DRAIN;
                DRAIN:   if (all_returned) state_r <= RUN;
                default: state_r <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_manycore_endpoint_out_sched.sv
// Randomized and directed bench for the endpoint output scheduler, scored against a cycle model of arbitration, credits and fencing.
module tb_bsg_manycore_endpoint_out_sched;

    localparam int N    = 4;
    localparam int PW   = 16;
    localparam int MAXC = 16;
    localparam int CW   = $clog2(MAXC + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_v;
    logic [N*PW-1:0]   req_data;
    logic [N-1:0]      yumi;
    logic [PW-1:0]     out_packet;
    logic              out_v;
    logic              out_ready;
    logic              credit_v;
    logic              fence_v;
    logic              fence_ready;
    logic              fence_done;
    logic [CW-1:0]     out_credits;
    logic              overflow;

    always #5 clk = ~clk;

    bsg_manycore_endpoint_out_sched #(
        .num_req_p(N), .packet_width_p(PW), .max_out_credits_p(MAXC)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .req_v_i(req_v), .req_data_i(req_data), .req_yumi_o(yumi),
        .out_packet_o(out_packet), .out_v_o(out_v), .out_ready_i(out_ready),
        .credit_v_i(credit_v), .fence_v_i(fence_v),
        .fence_ready_o(fence_ready), .fence_done_o(fence_done),
        .out_credits_o(out_credits), .credit_overflow_o(overflow)
    );

    // Reference model: outstanding-packet accounting and round-robin by plain integer search.
    int          m_cred  = MAXC;
    int          m_last  = N - 1;
    bit          m_drain = 1'b0;
    bit          m_ovf   = 1'b0;
    int          fired_slot;
    logic [PW-1:0] pkt [N];

    logic [N-1:0] req_mask;
    int          ready_mode, credit_pct, fence_pct, new_pct;
    int          checks = 0;
    int          errors = 0;
    int          nfire  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic eval_cycle();
        int  g;
        bit  ev, efire, done;
        logic [N-1:0] ey;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && req_v[(m_last + 1 + k) % N]) g = (m_last + 1 + k) % N;
        end
        ev    = rst_n && !m_drain && (m_cred != 0) && (g >= 0);
        efire = ev && out_ready;
        done  = rst_n && m_drain && (m_cred == MAXC);
        ey    = '0;
        if (efire) ey[g] = 1'b1;

        check_eq("out_v", out_v, ev);
        check_eq("yumi", yumi, ey);
        if (ev) check_eq("packet", out_packet, pkt[g]);
        check_eq("fence_ready", fence_ready, rst_n && !m_drain);
        check_eq("fence_done", fence_done, done);
        check_eq("credits", out_credits, m_cred);
        check_eq("overflow", overflow, m_ovf);
        if (yumi != '0) nfire++;

        fired_slot = efire ? g : -1;
        if (!rst_n) begin
            m_cred = MAXC; m_last = N - 1; m_drain = 1'b0; m_ovf = 1'b0;
        end else begin
            if (credit_v && m_cred == MAXC) m_ovf = 1'b1;
            m_cred = m_cred - int'(efire) + int'(credit_v && m_cred != MAXC);
            if (efire) m_last = g;
            if (!m_drain) m_drain = fence_v;
            else if (done) m_drain = 1'b0;
        end
    endtask

    task automatic drive_next();
        for (int i = 0; i < N; i++) begin
            if (fired_slot == i || !req_mask[i]) req_v[i] = 1'b0;
            if (!req_v[i] && req_mask[i] && ($urandom % 100) < new_pct) begin
                req_v[i] = 1'b1;
                pkt[i]   = PW'($urandom);
            end
            req_data[i*PW +: PW] = pkt[i];
        end
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = ($urandom % 100) < 60;
        endcase
        credit_v = (m_cred < MAXC) && (($urandom % 100) < credit_pct);
        fence_v  = ($urandom % 100) < fence_pct;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            eval_cycle();
            @(posedge clk);
            #1;
            drive_next();
        end
    endtask

    initial begin
        rst_n = 1'b0; credit_v = 1'b0; fence_v = 1'b0; out_ready = 1'b1;
        req_v = '0; req_data = '0; fired_slot = -1;
        for (int i = 0; i < N; i++) pkt[i] = '0;
        req_mask = 4'b1111; new_pct = 100; ready_mode = 0; credit_pct = 0; fence_pct = 0;
        @(posedge clk);
        #1;
        drive_next();
        run(2);

        // All requesters busy, no credits returned: 16 fires in round-robin order then stall.
        rst_n = 1'b1;
        nfire = 0;
        run(20);
        check_eq("t1_fires", nfire, 16);
        check_eq("t1_credits_zero", out_credits, 0);

        // One credit at zero count yields exactly one fire.
        nfire = 0;
        credit_v = 1'b1;
        run(1);
        check_eq("t2_credit_one", out_credits, 1);
        run(3);
        check_eq("t2_fires", nfire, 1);
        check_eq("t2_credits_zero", out_credits, 0);

        // Two requesters with toggling ready, credits flowing.
        req_mask = 4'b0101; ready_mode = 1; credit_pct = 60;
        run(40);

        // Fully random traffic with fences.
        req_mask = 4'b1111; new_pct = 50; ready_mode = 2; credit_pct = 40; fence_pct = 3;
        run(3000);

        // Drain everything, then return a credit too many.
        req_mask = '0; fence_pct = 0; credit_pct = 100;
        run(3 * MAXC);
        check_eq("t6_full", out_credits, MAXC);
        credit_pct = 0;
        credit_v = 1'b1;
        run(1);
        run(3);
        check_eq("t6_ovf_sticky", overflow, 1);
        check_eq("t6_saturated", out_credits, MAXC);

        // Reset while draining: back to RUN without a done pulse.
        req_mask = 4'b1111; new_pct = 100; ready_mode = 0;
        run(5);
        fence_v = 1'b1;
        run(1);
        run(2);
        check_eq("t6_draining", fence_ready, 0);
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        run(1);
        check_eq("t6_ready_after_rst", fence_ready, 1);
        check_eq("t6_ovf_cleared", overflow, 0);
        run(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
